// File: rtl/gb_dma_pkg.sv
// -----------------------------------------------------------------------------
// gb_dma_pkg
// Shared types and constants for the Game Boy OAM DMA engine.
//   dma_state_t  : engine state encoding (IDLE, SETUP, XFER, DRAIN)
//   DMA_REG_ADDR : CPU address of the DMA source register
//   OAM_LEN      : bytes copied per transfer
//   ECHO_BASE_HI / ECHO_OFFSET : echo-RAM page remap (0xE0..0xFF -> 0xC0..0xDF)
//   map_src_hi() : applies the echo-RAM remap to a written source page
// -----------------------------------------------------------------------------
package gb_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        DRAIN = 2'd3
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam int          OAM_LEN      = 160;
    localparam logic [7:0]  ECHO_BASE_HI = 8'hE0;
    localparam logic [7:0]  ECHO_OFFSET  = 8'h20;

    // Pages 0xE0 and up mirror work RAM, so the engine reads the real page.
    function automatic logic [7:0] map_src_hi(input logic [7:0] page);
        return (page >= ECHO_BASE_HI) ? (page - ECHO_OFFSET) : page;
    endfunction

endpackage

// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma
// Game Boy OAM DMA engine. A CPU write of XX to REG_ADDR copies LEN bytes from
// XX00.. into OAM 0x00.. one byte per clock, with the OAM write registered one
// cycle behind the combinational source read.
//
// Ports
//   clk, reset               : system clock, synchronous active-high reset
//   cpu_addr/cpu_wr/cpu_wdata: CPU bus write into the DMA register
//   mem_addr/mem_rd_cs       : source read request (combinational read)
//   mem_rd_data              : source read data, same cycle as the request
//   oam_addr/oam_wr_data/oam_wr_cs : registered OAM write port
//   dma_active               : locks the CPU out of non-HRAM space
//   cpu_rd/cpu_rdata         : register readback (only with OAM_DMA_READBACK_EN)
//
// Optional build macro: OAM_DMA_READBACK_EN adds the readback ports.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transfer; all bus outputs inactive
// SETUP | one cycle after the trigger; dma_active high, index cleared
// XFER  | LEN cycles; read {src_hi, index}, register it for the OAM write
// DRAIN | one cycle presenting the final OAM write, no source read
// -----------------------------------------------------------------------------
module oam_dma
    import gb_dma_pkg::*;
#(
    parameter int          LEN      = OAM_LEN,
    parameter logic [15:0] REG_ADDR = DMA_REG_ADDR,
    parameter int          OAM_ASZ  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        cpu_addr,
    input  logic               cpu_wr,
    input  logic [7:0]         cpu_wdata,
    output logic [15:0]        mem_addr,
    output logic               mem_rd_cs,
    input  logic [7:0]         mem_rd_data,
    output logic [OAM_ASZ-1:0] oam_addr,
    output logic [7:0]         oam_wr_data,
    output logic               oam_wr_cs,
`ifdef OAM_DMA_READBACK_EN
    input  logic               cpu_rd,
    output logic [7:0]         cpu_rdata,
`endif
    output logic               dma_active
);

    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

    dma_state_t         state_q,    state_d;
    logic [7:0]         index_q,    index_d;
    logic [7:0]         src_hi_q,   src_hi_d;
    logic               wr_valid_q, wr_valid_d;
    logic [OAM_ASZ-1:0] wr_idx_q,   wr_idx_d;
    logic [7:0]         wr_data_q,  wr_data_d;
    logic               trigger;

    assign trigger = cpu_wr && (cpu_addr == REG_ADDR);

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        src_hi_d   = src_hi_q;
        wr_valid_d = wr_valid_q;
        wr_idx_d   = wr_idx_q;
        wr_data_d  = wr_data_q;
        mem_addr   = 16'h0000;
        mem_rd_cs  = 1'b0;
        dma_active = (state_q != IDLE);

        case (state_q)
            IDLE: begin
            end
            SETUP: begin
                index_d    = 8'h00;
                wr_valid_d = 1'b0;
                state_d    = XFER;
            end
            XFER: begin
                mem_rd_cs  = 1'b1;
                mem_addr   = {src_hi_q, index_q};
                wr_data_d  = mem_rd_data;
                wr_idx_d   = OAM_ASZ'(index_q);
                wr_valid_d = 1'b1;
                if (index_q == LAST_IDX) begin
                    // Park the index at 0 so it never runs past LEN-1.
                    index_d = 8'h00;
                    state_d = DRAIN;
                end else begin
                    index_d = index_q + 8'h01;
                end
            end
            DRAIN: begin
                wr_valid_d = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A trigger in any state restarts. The write already on the OAM port
        // this cycle is captured by OAM at this edge; nothing after it is.
        if (trigger) begin
            src_hi_d   = map_src_hi(cpu_wdata);
            state_d    = SETUP;
            index_d    = 8'h00;
            wr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            index_q    <= 8'h00;
            src_hi_q   <= 8'h00;
            wr_valid_q <= 1'b0;
            wr_idx_q   <= '0;
            wr_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            src_hi_q   <= src_hi_d;
            wr_valid_q <= wr_valid_d;
            wr_idx_q   <= wr_idx_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign oam_wr_cs   = wr_valid_q;
    assign oam_addr    = wr_idx_q;
    assign oam_wr_data = wr_data_q;

`ifdef OAM_DMA_READBACK_EN
    logic [7:0] raw_reg_q, raw_reg_d;

    always_comb begin
        raw_reg_d = raw_reg_q;
        if (trigger) begin
            raw_reg_d = cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            raw_reg_q <= 8'h00;
        end else begin
            raw_reg_q <= raw_reg_d;
        end
    end

    // Readback returns the raw written page, before the echo remap.
    assign cpu_rdata = (cpu_rd && (cpu_addr == REG_ADDR)) ? raw_reg_q : 8'hFF;
`endif

endmodule

// File: tb/tb_oam_dma.sv
// -----------------------------------------------------------------------------
// tb_oam_dma
// Self-checking bench for oam_dma. A timeline reference model tracks the number
// of cycles since the last accepted trigger and derives every expected output
// from that count; an OAM array captures DUT writes and is compared against
// the page data the model expects.
// -----------------------------------------------------------------------------
module tb_oam_dma;

    localparam int LEN = 160;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_wr;
    logic [7:0]  cpu_wdata;
    logic [15:0] mem_addr;
    logic        mem_rd_cs;
    logic [7:0]  mem_rd_data;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wr_data;
    logic        oam_wr_cs;
    logic        dma_active;
`ifdef OAM_DMA_READBACK_EN
    logic        cpu_rd;
    logic [7:0]  cpu_rdata;
`endif

    int checks = 0;
    int errors = 0;

    oam_dma #(.LEN(LEN), .REG_ADDR(16'hFF46), .OAM_ASZ(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_wr     (cpu_wr),
        .cpu_wdata  (cpu_wdata),
        .mem_addr   (mem_addr),
        .mem_rd_cs  (mem_rd_cs),
        .mem_rd_data(mem_rd_data),
        .oam_addr   (oam_addr),
        .oam_wr_data(oam_wr_data),
        .oam_wr_cs  (oam_wr_cs),
`ifdef OAM_DMA_READBACK_EN
        .cpu_rd     (cpu_rd),
        .cpu_rdata  (cpu_rdata),
`endif
        .dma_active (dma_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source memory: C0 page holds addr[7:0]^0x5A, other pages are offset so
    // a transfer from the wrong page is visible.
    function automatic logic [7:0] src_byte(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'hC0);
    endfunction

    assign mem_rd_data = src_byte(mem_addr);

    logic [7:0] oam_mem [256];
    logic [7:0] exp_oam [256];

    always @(posedge clk) begin
        if (oam_wr_cs) oam_mem[oam_addr] <= oam_wr_data;
    end

    // Reference model state
    bit         m_valid;
    int         m_k;
    logic [7:0] m_page;
    logic [7:0] m_raw;
    bit         m_zero_wr;

    task automatic check_outputs();
        logic        e_act, e_rd, e_wr;
        logic [15:0] e_maddr;
        logic [7:0]  e_oaddr, e_odata;
        e_act   = m_valid;
        e_rd    = m_valid && m_k >= 2 && m_k <= LEN + 1;
        e_wr    = m_valid && m_k >= 3;
        e_maddr = e_rd ? {m_page, 8'(m_k - 2)} : 16'h0000;
        e_oaddr = e_wr ? 8'(m_k - 3) : 8'h00;
        e_odata = e_wr ? src_byte({m_page, 8'(m_k - 3)}) : 8'h00;
        checks++;
        if (dma_active !== e_act || mem_rd_cs !== e_rd || mem_addr !== e_maddr ||
            oam_wr_cs !== e_wr ||
            ((e_wr || m_zero_wr) && (oam_addr !== e_oaddr || oam_wr_data !== e_odata))) begin
            errors++;
            $display("FAIL cycle_out t=%0t got act=%b rd=%b maddr=%h wr=%b oaddr=%h odata=%h exp act=%b rd=%b maddr=%h wr=%b oaddr=%h odata=%h",
                     $time, dma_active, mem_rd_cs, mem_addr, oam_wr_cs, oam_addr, oam_wr_data,
                     e_act, e_rd, e_maddr, e_wr, e_oaddr, e_odata);
        end
        if (e_wr) begin
            exp_oam[e_oaddr] = e_odata;
            m_zero_wr = 1'b0;
        end
    endtask

    task automatic cycle(input bit r, input bit wr, input logic [15:0] a, input logic [7:0] d);
        reset = r; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0; m_zero_wr = 1'b1; m_raw = 8'h00;
        end else if (wr && a == 16'hFF46) begin
            m_valid = 1'b1; m_k = 1;
            m_page  = (d >= 8'hE0) ? d - 8'h20 : d;
            m_raw   = d;
        end else if (m_valid) begin
            m_k++;
            if (m_k > LEN + 2) m_valid = 1'b0;
        end
        #1;
        reset = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic check_page(input string name, input logic [7:0] page, input int lo, input int hi);
        int bad;
        bad = 0;
        for (int i = lo; i <= hi; i++)
            if (oam_mem[i] !== src_byte({page, 8'(i)})) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s page=%h bytes %0d..%0d: %0d bytes differ, oam[%0d]=%h want %h",
                     name, page, lo, hi, bad, lo, oam_mem[lo], src_byte({page, 8'(lo)}));
        end
    endtask

    task automatic check_oam_model(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) if (oam_mem[i] !== exp_oam[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d OAM bytes differ from model, got 0 mismatching entries required", name, bad);
        end
    endtask

`ifdef OAM_DMA_READBACK_EN
    task automatic check_read(input string name, input logic [15:0] a, input bit rd, input logic [7:0] exp);
        cpu_addr = a; cpu_rd = rd;
        #1;
        checks++;
        if (cpu_rdata !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, cpu_rdata, exp);
        end
        cpu_rd = 1'b0; cpu_addr = 16'h0000;
    endtask
`endif

    typedef struct {
        logic [7:0] wdata;
        logic [7:0] page;
    } vec_t;
    vec_t tbl [4];

    logic [7:0] snap [256];

    initial begin
        for (int i = 0; i < 256; i++) begin oam_mem[i] = 8'h00; exp_oam[i] = 8'h00; end
        m_valid = 1'b0; m_k = 0; m_page = 8'h00; m_raw = 8'h00; m_zero_wr = 1'b1;
        reset = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
`ifdef OAM_DMA_READBACK_EN
        cpu_rd = 1'b0;
`endif
        tbl[0] = '{wdata: 8'hC0, page: 8'hC0};
        tbl[1] = '{wdata: 8'hE1, page: 8'hC1};
        tbl[2] = '{wdata: 8'hFE, page: 8'hDE};
        tbl[3] = '{wdata: 8'hDF, page: 8'hDF};

        // Reset state
        cycle(1'b1, 1'b0, 16'h0000, 8'h00);
        cycle(1'b1, 1'b0, 16'h0000, 8'h00);
        idle(2);

        // Table-driven full transfers, including echo-page remap
        foreach (tbl[v]) begin
            cycle(1'b0, 1'b1, 16'hFF46, tbl[v].wdata);
            idle(LEN + 4);
            check_page("xfer_table", tbl[v].page, 0, LEN - 1);
        end

        // Writes to neighbouring addresses are ignored
        cycle(1'b0, 1'b1, 16'hFF47, 8'hC0);
        cycle(1'b0, 1'b1, 16'hFF45, 8'hC0);
        idle(3);

        // Restart at T+50: byte 47 of C0 completes, then D0 runs to completion
        cycle(1'b0, 1'b1, 16'hFF46, 8'hC0);
        idle(49);
        cycle(1'b0, 1'b1, 16'hFF46, 8'hD0);
        check_page("restart_partial_c0", 8'hC0, 0, 8'h2F);
        idle(LEN + 4);
        check_page("restart_final_d0", 8'hD0, 0, LEN - 1);

        // Reset at T+80 mid-transfer: no OAM write after the reset edge
        cycle(1'b0, 1'b1, 16'hFF46, 8'hC2);
        idle(79);
        cycle(1'b1, 1'b0, 16'h0000, 8'h00);
        for (int i = 0; i < 256; i++) snap[i] = oam_mem[i];
        idle(6);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 256; i++) if (oam_mem[i] !== snap[i]) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL reset_no_write: %0d bytes changed after reset, required 0", bad);
            end
        end

        // Reset and trigger in the same cycle: stays idle
        cycle(1'b1, 1'b1, 16'hFF46, 8'hC0);
        idle(3);
        checks++;
        if (dma_active !== 1'b0) begin
            errors++;
            $display("FAIL reset_trigger_same_cycle dma_active=%b required 0", dma_active);
        end

`ifdef OAM_DMA_READBACK_EN
        check_read("rb_after_reset", 16'hFF46, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 16'hFF46, 8'hE5);
        check_read("rb_ff46", 16'hFF46, 1'b1, 8'hE5);
        check_read("rb_ff47", 16'hFF47, 1'b1, 8'hFF);
        check_read("rb_no_rd", 16'hFF46, 1'b0, 8'hFF);
        idle(LEN + 4);
        cycle(1'b1, 1'b0, 16'h0000, 8'h00);
        check_read("rb_reset_clears", 16'hFF46, 1'b1, m_raw);
`endif

        // Randomized traffic against the timeline model
        for (int n = 0; n < 3000; n++) begin
            bit         r, w;
            logic [15:0] a;
            logic [7:0]  d;
            r = ($urandom_range(0, 299) == 0);
            w = ($urandom_range(0, 119) == 0);
            case ($urandom_range(0, 3))
                0:       a = 16'hFF47;
                1:       a = 16'($urandom);
                default: a = 16'hFF46;
            endcase
            d = 8'($urandom);
            cycle(r, w, a, d);
        end
        idle(LEN + 4);
        check_oam_model("random_oam_contents");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
